regfile_writeback: RTL and testbench

Write-side front end of the integer register file: accepts completed results from the ALU and the load/store unit over valid/ready handshakes, arbitrates between them, and drives the register file's single write port one cycle later. It keeps a per-register pending-write scoreboard so decode can stall on RAW/WAW hazards. It optionally forwards the in-flight write data to decode's operand reads.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/wb_scoreboard.sv | 40 ++++
 rtl/regfile_writeback.sv | 125 ++++++++++++
 tb/tb_regfile_writeback.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing and source encoding for the integer register-file write side.
package regfile_pkg;
  localparam int NREGS        = 32;
  localparam int ADDR_W       = $clog2(NREGS);
  localparam int STARVE_LIMIT = 3;

  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LSU} wb_src_e;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, register 0 never busy.
// A set and a clear of the same register on one edge leave the bit set.
module wb_scoreboard
  import regfile_pkg::*;
#(
  parameter int SB_NREGS  = NREGS,
  parameter int SB_ADDR_W = ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_set,
  input  logic [SB_ADDR_W-1:0] i_set_rd,
  input  logic                 i_clr,
  input  logic [SB_ADDR_W-1:0] i_clr_rd,
  input  logic [SB_ADDR_W-1:0] i_q1_rd,
  input  logic [SB_ADDR_W-1:0] i_q2_rd,
  input  logic [SB_ADDR_W-1:0] i_iq_rd,
  output logic                 o_q1_busy,
  output logic                 o_q2_busy,
  output logic                 o_iq_busy
);
  logic [SB_NREGS-1:0] r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < SB_NREGS; i++) begin
        if (i_set && i_set_rd == SB_ADDR_W'(i))
          r_busy[i] <= 1'b1;
        else if (i_clr && i_clr_rd == SB_ADDR_W'(i))
          r_busy[i] <= 1'b0;
      end
    end
  end

  assign o_q1_busy = r_busy[i_q1_rd];
  assign o_q2_busy = r_busy[i_q2_rd];
  assign o_iq_busy = r_busy[i_iq_rd];
endmodule

// File: rtl/regfile_writeback.sv
// Register-file write front end: LSU/ALU arbitration with ALU starvation guard,
// one-cycle write register, and hazard scoreboard. Define WB_FORWARD_EN to forward rf_data.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int WB_NREGS        = NREGS,
  parameter int WB_ADDR_W       = ADDR_W,
  parameter int WB_STARVE_LIMIT = STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_issue_valid,
  input  logic [WB_ADDR_W-1:0] i_issue_rd,
  output logic                 o_issue_ready,
  input  logic                 i_alu_valid,
  output logic                 o_alu_ready,
  input  logic [WB_ADDR_W-1:0] i_alu_rd,
  input  logic [31:0]          i_alu_data,
  input  logic                 i_lsu_valid,
  output logic                 o_lsu_ready,
  input  logic [WB_ADDR_W-1:0] i_lsu_rd,
  input  logic [31:0]          i_lsu_data,
  output logic                 o_rf_we,
  output logic [WB_ADDR_W-1:0] o_rf_rd,
  output logic [31:0]          o_rf_data,
  input  logic [WB_ADDR_W-1:0] i_rs1,
  input  logic [WB_ADDR_W-1:0] i_rs2,
  output logic                 o_rs1_busy,
  output logic                 o_rs2_busy,
  output logic                 o_rs1_fwd,
  output logic                 o_rs2_fwd
);
  localparam int CNT_W = (WB_STARVE_LIMIT > 1) ? $clog2(WB_STARVE_LIMIT + 1) : 1;

  logic [CNT_W-1:0]     r_cnt;
  logic                 r_we;
  logic [WB_ADDR_W-1:0] r_rd;
  logic [31:0]          r_data;

  wb_src_e              w_src;
  logic                 w_starve;
  logic [WB_ADDR_W-1:0] w_rd;
  logic [31:0]          w_data;
  logic                 w_q1_busy, w_q2_busy, w_iq_busy;
  logic                 w_rs1_fwd, w_rs2_fwd;

  // ALU wins only once the LSU has taken STARVE_LIMIT grants in a row over it.
  assign w_starve = i_alu_valid && i_lsu_valid && (r_cnt == CNT_W'(WB_STARVE_LIMIT));

  always_comb begin
    w_src  = WB_NONE;
    w_rd   = i_alu_rd;
    w_data = i_alu_data;
    if (i_lsu_valid && !w_starve) begin
      w_src  = WB_LSU;
      w_rd   = i_lsu_rd;
      w_data = i_lsu_data;
    end else if (i_alu_valid) begin
      w_src  = WB_ALU;
    end
  end

  assign o_alu_ready = (w_src == WB_ALU);
  assign o_lsu_ready = (w_src == WB_LSU);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_alu_valid || w_src == WB_ALU) begin
      r_cnt <= '0;
    end else if (w_src == WB_LSU && r_cnt != CNT_W'(WB_STARVE_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // rd=0 results are consumed but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else if (w_src != WB_NONE) begin
      r_we   <= (w_rd != '0);
      r_rd   <= w_rd;
      r_data <= w_data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  assign o_rf_we   = r_we;
  assign o_rf_rd   = r_rd;
  assign o_rf_data = r_data;

`ifdef WB_FORWARD_EN
  assign w_rs1_fwd     = r_we && (r_rd == i_rs1) && (i_rs1 != '0);
  assign w_rs2_fwd     = r_we && (r_rd == i_rs2) && (i_rs2 != '0);
  assign o_issue_ready = !w_iq_busy;
`else
  assign w_rs1_fwd     = 1'b0;
  assign w_rs2_fwd     = 1'b0;
  // Without forwarding, a register being written this cycle cannot be re-issued yet.
  assign o_issue_ready = !w_iq_busy && !(r_we && (r_rd == i_issue_rd));
`endif

  wb_scoreboard #(.SB_NREGS(WB_NREGS), .SB_ADDR_W(WB_ADDR_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .i_set     (i_issue_valid && o_issue_ready),
    .i_set_rd  (i_issue_rd),
    .i_clr     (r_we),
    .i_clr_rd  (r_rd),
    .i_q1_rd   (i_rs1),
    .i_q2_rd   (i_rs2),
    .i_iq_rd   (i_issue_rd),
    .o_q1_busy (w_q1_busy),
    .o_q2_busy (w_q2_busy),
    .o_iq_busy (w_iq_busy)
  );

  assign o_rs1_fwd  = w_rs1_fwd;
  assign o_rs2_fwd  = w_rs2_fwd;
  assign o_rs1_busy = w_q1_busy && !w_rs1_fwd;
  assign o_rs2_busy = w_q2_busy && !w_rs2_fwd;
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized
// traffic against a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_writeback;
  import regfile_pkg::*;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid, issue_ready;
  logic [ADDR_W-1:0] issue_rd;
  logic              alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [ADDR_W-1:0] alu_rd, lsu_rd;
  logic [31:0]       alu_data, lsu_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [31:0]       rf_data;
  logic [ADDR_W-1:0] rs1, rs2;
  logic              rs1_busy, rs2_busy, rs1_fwd, rs2_fwd;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_writeback dut (
    .clk(clk), .rst(rst),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .o_issue_ready(issue_ready),
    .i_alu_valid(alu_valid), .o_alu_ready(alu_ready), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data),
    .o_rf_we(rf_we), .o_rf_rd(rf_rd), .o_rf_data(rf_data),
    .i_rs1(rs1), .i_rs2(rs2),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy), .o_rs1_fwd(rs1_fwd), .o_rs2_fwd(rs2_fwd)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  bit          m_busy [NREGS];
  int          m_cnt;
  bit          m_we;
  int          m_rd;
  logic [31:0] m_data;
  int          e_grant; // 0 none, 1 ALU, 2 LSU
  bit          e_iss_rdy, e_rs1_fwd, e_rs2_fwd, e_rs1_busy, e_rs2_busy;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_cnt = 0; m_we = 1'b0; m_rd = 0; m_data = 32'h0;
  endtask

  task automatic model_eval();
    bit starve;
    starve = alu_valid && lsu_valid && (m_cnt == STARVE_LIMIT);
    if (lsu_valid && !starve) e_grant = 2;
    else if (alu_valid)       e_grant = 1;
    else                      e_grant = 0;
    e_rs1_fwd  = FWD && m_we && (m_rd == int'(rs1)) && (rs1 != 0);
    e_rs2_fwd  = FWD && m_we && (m_rd == int'(rs2)) && (rs2 != 0);
    e_rs1_busy = m_busy[rs1] && !e_rs1_fwd;
    e_rs2_busy = m_busy[rs2] && !e_rs2_fwd;
    e_iss_rdy  = !m_busy[issue_rd] && (FWD || !(m_we && m_rd == int'(issue_rd)));
  endtask

  task automatic model_update();
    if (m_we) m_busy[m_rd] = 1'b0;
    if (issue_valid && e_iss_rdy && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (!alu_valid || e_grant == 1) m_cnt = 0;
    else if (e_grant == 2)          m_cnt = (m_cnt < STARVE_LIMIT) ? m_cnt + 1 : STARVE_LIMIT;
    if (e_grant == 1) begin
      m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data;
    end else if (e_grant == 2) begin
      m_we = (lsu_rd != 0); m_rd = lsu_rd; m_data = lsu_data;
    end else begin
      m_we = 1'b0;
    end
  endtask

  // Advance one clock: inputs are held across the edge, model follows the edge.
  task automatic cycle();
    model_eval();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0; rs1 = 0; rs2 = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    n_tests++; if (rf_we !== 1'b0)  begin n_fail++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    n_tests++; if (rf_rd !== '0)    begin n_fail++; $display("FAIL reset_rf_rd got=%0d exp=0", rf_rd); end
    n_tests++; if (rf_data !== '0)  begin n_fail++; $display("FAIL reset_rf_data got=%h exp=0", rf_data); end
    issue_rd = 7; rs1 = 7; rs2 = 31; #1;
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready); end
    n_tests++; if ({rs1_busy, rs2_busy, rs1_fwd, rs2_fwd} !== 4'b0)
      begin n_fail++; $display("FAIL reset_operands got=%b exp=0000", {rs1_busy, rs2_busy, rs1_fwd, rs2_fwd}); end
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_alu_basic();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; #1;
    n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_basic_ready got=%b exp=1", alu_ready); end
    cycle();
    alu_valid = 0; #1;
    n_tests++; if ({rf_we, rf_rd, rf_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
      begin n_fail++; $display("FAIL alu_basic_write got=%b/%0d/%h exp=1/5/deadbeef", rf_we, rf_rd, rf_data); end
    cycle();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_basic_we_drop got=%b exp=0", rf_we); end
  endtask

  task automatic test_priority();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44; #1;
    n_tests++; if ({alu_ready, lsu_ready} !== 2'b01)
      begin n_fail++; $display("FAIL prio_ready got=%b exp=01", {alu_ready, lsu_ready}); end
    cycle();
    lsu_valid = 0; #1;
    n_tests++; if ({rf_we, rf_rd} !== {1'b1, 5'd4}) begin n_fail++; $display("FAIL prio_first got=%b/%0d exp=1/4", rf_we, rf_rd); end
    n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL prio_alu_next got=%b exp=1", alu_ready); end
    cycle();
    alu_valid = 0; #1;
    n_tests++; if ({rf_we, rf_rd, rf_data} !== {1'b1, 5'd3, 32'h33})
      begin n_fail++; $display("FAIL prio_second got=%b/%0d/%h exp=1/3/33", rf_we, rf_rd, rf_data); end
    cycle();
  endtask

  task automatic test_starvation();
    bit [7:0] pat; // 1 = ALU expected; first grant in bit 7
    pat = 8'b0001_0001;
    alu_rd = 10; lsu_rd = 11;
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1; lsu_valid = 1; alu_data = i; lsu_data = 100 + i;
      cycle();
      n_tests++; if (rf_rd !== (pat[7-i] ? 5'd10 : 5'd11))
        begin n_fail++; $display("FAIL starve_grant%0d got_rd=%0d exp_rd=%0d", i, rf_rd, pat[7-i] ? 10 : 11); end
    end
    alu_valid = 0; lsu_valid = 0;
    cycle();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_rd = 7; rs1 = 7; #1;
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sb_issue1 got=%b exp=1", issue_ready); end
    cycle(); #1;
    n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sb_waw got=%b exp=0", issue_ready); end
    n_tests++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_set got=%b exp=1", rs1_busy); end
    issue_valid = 0;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h7777;
    cycle();
    lsu_valid = 0; #1;
    n_tests++; if ({rs1_busy, rs1_fwd} !== {!FWD, FWD})
      begin n_fail++; $display("FAIL sb_wb_cycle got=%b%b exp=%b%b", rs1_busy, rs1_fwd, !FWD, FWD); end
    cycle();
    n_tests++; if ({rs1_busy, rs1_fwd} !== 2'b00)
      begin n_fail++; $display("FAIL sb_cleared got=%b%b exp=00", rs1_busy, rs1_fwd); end
  endtask

  task automatic test_rd_zero();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; #1;
    n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready got=%b exp=1", alu_ready); end
    cycle();
    alu_valid = 0; issue_valid = 1; issue_rd = 0; rs1 = 0; #1;
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we got=%b exp=0", rf_we); end
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_issue got=%b exp=1", issue_ready); end
    cycle();
    issue_valid = 0; #1;
    n_tests++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL rd0_busy got=%b exp=0", rs1_busy); end
  endtask

  task automatic test_issue_clear_same();
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    cycle();
    alu_valid = 0; issue_valid = 1; issue_rd = 9; rs1 = 9; #1;
    model_eval();
    n_tests++; if (issue_ready !== e_iss_rdy) begin n_fail++; $display("FAIL same_issue_ready got=%b exp=%b", issue_ready, e_iss_rdy); end
    cycle();
    issue_valid = 0; #1;
    model_eval();
    n_tests++; if (rs1_busy !== e_rs1_busy || rs1_busy !== FWD)
      begin n_fail++; $display("FAIL same_busy9 got=%b exp=%b", rs1_busy, FWD); end
  endtask

  task automatic test_random();
    bit          a_v, l_v;
    logic [4:0]  a_rd, l_rd;
    logic [31:0] a_d, l_d;
    a_v = 0; l_v = 0; a_rd = 0; l_rd = 0; a_d = 0; l_d = 0;
    for (int c = 0; c < 400; c++) begin
      if (!a_v && c < 390) begin a_v = ($urandom_range(0, 2) != 0); a_rd = $urandom_range(0, 7); a_d = $urandom; end
      if (!l_v && c < 390) begin l_v = ($urandom_range(0, 1) != 0); l_rd = $urandom_range(0, 7); l_d = $urandom; end
      alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
      lsu_valid = l_v; lsu_rd = l_rd; lsu_data = l_d;
      issue_valid = $urandom_range(0, 1); issue_rd = $urandom_range(0, 7);
      rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7);
      #1;
      model_eval();
      n_tests++;
      if ((a_v && alu_ready !== (e_grant == 1)) || (l_v && lsu_ready !== (e_grant == 2))) begin
        n_fail++; $display("FAIL rand_ready c=%0d got=%b%b exp_grant=%0d", c, alu_ready, lsu_ready, e_grant);
      end
      n_tests++; if (issue_ready !== e_iss_rdy) begin n_fail++; $display("FAIL rand_issue c=%0d got=%b exp=%b", c, issue_ready, e_iss_rdy); end
      n_tests++; if (rf_we !== m_we) begin n_fail++; $display("FAIL rand_we c=%0d got=%b exp=%b", c, rf_we, m_we); end
      n_tests++; if (rf_rd !== 5'(m_rd) || rf_data !== m_data)
        begin n_fail++; $display("FAIL rand_wdata c=%0d got=%0d/%h exp=%0d/%h", c, rf_rd, rf_data, m_rd, m_data); end
      n_tests++; if ({rs1_busy, rs2_busy, rs1_fwd, rs2_fwd} !== {e_rs1_busy, e_rs2_busy, e_rs1_fwd, e_rs2_fwd})
        begin n_fail++; $display("FAIL rand_ops c=%0d got=%b exp=%b", c, {rs1_busy, rs2_busy, rs1_fwd, rs2_fwd},
                                 {e_rs1_busy, e_rs2_busy, e_rs1_fwd, e_rs2_fwd}); end
      if (e_grant == 1) a_v = 0;
      if (e_grant == 2) l_v = 0;
      cycle();
    end
    n_tests++; if (a_v || l_v) begin n_fail++; $display("FAIL rand_drain got=%b%b exp=00", a_v, l_v); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bit any_busy;
    issue_valid = 1; issue_rd = 14;
    alu_valid = 1; alu_rd = 12; alu_data = 32'hA12;
    lsu_valid = 1; lsu_rd = 13; lsu_data = 32'hB13;
    cycle();
    issue_valid = 0; lsu_valid = 0;
    #2 rst = 1'b1;
    #1;
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we got=%b exp=0", rf_we); end
    any_busy = 0;
    for (int r = 0; r < NREGS; r++) begin
      rs1 = r; #0.1;
      if (rs1_busy !== 1'b0) any_busy = 1;
    end
    n_tests++; if (any_busy) begin n_fail++; $display("FAIL midrst_busy got=1 exp=0"); end
    @(posedge clk); #3;
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_represent got=%b exp=1", alu_ready); end
    @(posedge clk); #1;
    cycle();
    alu_valid = 0; #1;
    n_tests++; if ({rf_we, rf_rd, rf_data} !== {1'b1, 5'd12, 32'hA12})
      begin n_fail++; $display("FAIL midrst_write got=%b/%0d/%h exp=1/12/a12", rf_we, rf_rd, rf_data); end
    cycle();
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_priority();
    test_starvation();
    test_scoreboard();
    test_rd_zero();
    test_issue_clear_same();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
